// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
//
// Gathers a serial stream of complex 16-bit samples into a D_WIDTH-entry frame
// buffer (natural arrival order). When the frame is complete and the FFT core
// is free, it issues a single-cycle start pulse. It then immediately begins
// refilling for the next frame while the FFT computes. The FFT copies its
// inputs on start, so overwriting the buffer during the transform is safe.
// All state advances on the falling clock edge, matching the FFT core.
//
// Ports:
//   clk            clock (state updates on falling edge)
//   rst            asynchronous reset, active-low
//   in_valid       sample present on in_re/in_im
//   in_re, in_im   sample real/imaginary parts, two's complement
//   in_ready       loader accepts a sample this cycle
//   flush          synchronous abandon of the partial frame
//   fft_done       done pulse from the FFT core
//   fft_start      registered one-cycle start pulse to the FFT core
//   frame_re/im    buffered samples, entry i at bits [16*i +: 16]
//   fft_busy       FFT started and not yet reported done
//   frames_issued  count of start pulses issued (wraps)
// -----------------------------------------------------------------------------
module fft_frame_loader #(
    parameter int D_WIDTH = 64,
    parameter int PTR_W   = 6,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [15:0]           in_re,
    input  logic [15:0]           in_im,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  fft_done,
    output logic                  fft_start,
    output logic [16*D_WIDTH-1:0] frame_re,
    output logic [16*D_WIDTH-1:0] frame_im,
    output logic                  fft_busy,
    output logic [CNT_W-1:0]      frames_issued
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FULL = 2'd1,
        S_FIRE = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(D_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [16*D_WIDTH-1:0]   frame_re_q, frame_im_q;
    logic                    accept;

    // Flush forces ready low so a sample offered alongside a flush is
    // visibly refused rather than silently dropped.
    assign in_ready      = rst & (state_q == S_FILL) & ~flush;
    assign accept        = in_valid & in_ready;

    assign fft_start     = start_q;
    assign fft_busy      = busy_q;
    assign frames_issued = cnt_q;
    assign frame_re      = frame_re_q;
    assign frame_im      = frame_im_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        cnt_d    = cnt_q;

        // A done with nothing running simply leaves busy low.
        if (fft_done) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_FILL: begin
                if (flush) begin
                    wr_ptr_d = '0;
                end else if (accept) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (flush) begin
                    state_d  = S_FILL;
                    wr_ptr_d = '0;
                end else if (!busy_q || fft_done) begin
                    // A done on this edge frees the core in time to fire
                    // without an idle cycle in between.
                    state_d = S_FIRE;
                    start_d = 1'b1;
                end
            end
            S_FIRE: begin
                // Start is committed: flush is ignored here.
                state_d = S_FILL;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d  = S_FILL;
                wr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer writes happen only in FILL, so the frame is stable through FULL
    // and FIRE and the FFT samples it cleanly on the edge after start.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            frame_re_q <= '0;
            frame_im_q <= '0;
        end else if (accept && !flush) begin
            frame_re_q[{wr_ptr_q, 4'b0000} +: 16] <= in_re;
            frame_im_q[{wr_ptr_q, 4'b0000} +: 16] <= in_im;
        end
    end

endmodule
